// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with handshaked data memory access and wait timeout
//
// Purpose: registers the MEM/WB outputs. Loads and stores are issued to the data
// memory as a held request and wait for dmem_ack. Every other valid instruction
// passes straight through. An access that waits too long is abandoned and sets a
// sticky error flag.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   check_in, alu_in, b_in, ir_in   EX/MEM register outputs
//   stall_out                       freeze request to EX/MEM
//   dmem_req/we/addr/wdata          data memory request, held for the whole access
//   dmem_rdata, dmem_ack            data memory response
//   check_out, alu_out, lmd_out,
//   ir_out                          MEM/WB register
//   err_out                         sticky access-timeout flag
module mem_stage #(
    parameter logic [5:0] LW_OP   = 6'b001000,
    parameter logic [5:0] SW_OP   = 6'b001001,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        check_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] b_in,
    input  logic [31:0] ir_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        check_out,
    output logic [31:0] alu_out,
    output logic [31:0] lmd_out,
    output logic [31:0] ir_out,
    output logic        err_out
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   ir_lat;
    logic [31:0]   alu_lat;

    logic [5:0] opcode;
    logic       is_mem;
    logic       timeout_hit;

    assign opcode = ir_in[31:26];
    assign is_mem = check_in && ((opcode == LW_OP) || (opcode == SW_OP));

    // An ack on the last allowed cycle wins over the timeout.
    assign timeout_hit = (state == ACCESS) && (wait_cnt == CNT_LAST) && !dmem_ack;

    // In IDLE the freeze depends only on the incoming instruction; in ACCESS it
    // lifts in the cycle the access finishes, so EX/MEM advances on that edge.
    always_comb begin
        stall_out = 1'b0;
        if (state == IDLE) begin
            stall_out = is_mem;
        end else begin
            stall_out = !(dmem_ack || timeout_hit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (is_mem) state_nx = ACCESS;
            ACCESS:  if (dmem_ack || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            ir_lat     <= '0;
            alu_lat    <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            check_out  <= 1'b0;
            alu_out    <= '0;
            lmd_out    <= '0;
            ir_out     <= '0;
            err_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        wait_cnt   <= '0;
                        ir_lat     <= ir_in;
                        alu_lat    <= alu_in;
                        dmem_req   <= 1'b1;
                        dmem_we    <= (opcode == SW_OP);
                        dmem_addr  <= alu_in;
                        dmem_wdata <= b_in;
                        check_out  <= 1'b0;
                    end else if (check_in) begin
                        check_out <= 1'b1;
                        alu_out   <= alu_in;
                        ir_out    <= ir_in;
                    end else begin
                        check_out <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        check_out <= 1'b1;
                        ir_out    <= ir_lat;
                        alu_out   <= alu_lat;
                        // dmem_we still identifies the access: low means load.
                        if (!dmem_we) lmd_out <= dmem_rdata;
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                    end else if (timeout_hit) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        err_out   <= 1'b1;
                        check_out <= 1'b0;
                    end else begin
                        wait_cnt  <= wait_cnt + CW'(1);
                        check_out <= 1'b0;
                    end
                end
                default: check_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed vector and sequence bench for mem_stage
module tb_mem_stage;

    localparam logic [5:0] LW = 6'b001000;
    localparam logic [5:0] SW = 6'b001001;

    logic        clk;
    logic        rst_n;
    logic        check_in;
    logic [31:0] alu_in, b_in, ir_in;
    logic        stall_out;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        check_out;
    logic [31:0] alu_out, lmd_out, ir_out;
    logic        err_out;

    int vectors = 0;
    int errors  = 0;

    mem_stage #(.LW_OP(LW), .SW_OP(SW), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .check_in(check_in), .alu_in(alu_in),
        .b_in(b_in), .ir_in(ir_in), .stall_out(stall_out),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .check_out(check_out), .alu_out(alu_out), .lmd_out(lmd_out),
        .ir_out(ir_out), .err_out(err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        check_in;
        logic [31:0] alu;
        logic [31:0] ir;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_stall;
        logic        exp_check;
        logic [31:0] exp_alu;
        logic [31:0] exp_ir;
        logic [31:0] exp_lmd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ci, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ir, input logic ack, input logic [31:0] rd);
        check_in   = ci;
        alu_in     = a;
        b_in       = b;
        ir_in      = ir;
        dmem_ack   = ack;
        dmem_rdata = rd;
        #1;
    endtask

    vec_t vt[4];

    initial begin
        vt[0] = '{1'b1, 32'h5,  32'h0000_0020,     1'b0, 32'h0,
                  1'b0, 1'b1, 32'h5, 32'h0000_0020, 32'h0};
        vt[1] = '{1'b0, 32'h99, 32'hFFFF_FFFF,     1'b0, 32'h0,
                  1'b0, 1'b0, 32'h5, 32'h0000_0020, 32'h0};
        vt[2] = '{1'b0, 32'h11, {LW, 26'h3},       1'b1, 32'hAAAA_AAAA,
                  1'b0, 1'b0, 32'h5, 32'h0000_0020, 32'h0};
        vt[3] = '{1'b1, 32'h7,  {6'b001010, 26'h1}, 1'b1, 32'hBBBB_BBBB,
                  1'b0, 1'b1, 32'h7, {6'b001010, 26'h1}, 32'h0};

        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        #12;
        chk("rst_check_out", {31'h0, check_out}, 32'h0);
        chk("rst_req",       {31'h0, dmem_req},  32'h0);
        chk("rst_err",       {31'h0, err_out},   32'h0);
        chk("rst_alu_out",   alu_out,            32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single-cycle IDLE behaviour from the table.
        for (int i = 0; i < 4; i++) begin
            drive(vt[i].check_in, vt[i].alu, 32'h0, vt[i].ir, vt[i].ack, vt[i].rdata);
            chk($sformatf("v%0d_stall", i), {31'h0, stall_out}, {31'h0, vt[i].exp_stall});
            tick();
            chk($sformatf("v%0d_check", i), {31'h0, check_out}, {31'h0, vt[i].exp_check});
            chk($sformatf("v%0d_alu", i), alu_out, vt[i].exp_alu);
            chk($sformatf("v%0d_ir", i),  ir_out,  vt[i].exp_ir);
            chk($sformatf("v%0d_lmd", i), lmd_out, vt[i].exp_lmd);
            chk($sformatf("v%0d_req", i), {31'h0, dmem_req}, 32'h0);
        end

        // LW, ack arrives in the second ACCESS cycle.
        drive(1'b1, 32'h40, 32'h0, {LW, 26'h3}, 1'b0, 32'h0);
        chk("lw_stall_idle", {31'h0, stall_out}, 32'h1);
        tick();
        drive(1'b1, 32'hFFF0, 32'h5555, {SW, 26'h0}, 1'b0, 32'h0);
        chk("lw_req",       {31'h0, dmem_req},  32'h1);
        chk("lw_we",        {31'h0, dmem_we},   32'h0);
        chk("lw_addr",      dmem_addr,          32'h40);
        chk("lw_check0",    {31'h0, check_out}, 32'h0);
        chk("lw_stall_acc", {31'h0, stall_out}, 32'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("lw_addr_hold", dmem_addr,          32'h40);
        chk("lw_stall_ack", {31'h0, stall_out}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("lw_check1", {31'h0, check_out}, 32'h1);
        chk("lw_lmd",    lmd_out,            32'hDEAD_BEEF);
        chk("lw_alu",    alu_out,            32'h40);
        chk("lw_ir",     ir_out,             {LW, 26'h3});
        chk("lw_req0",   {31'h0, dmem_req},  32'h0);
        tick();
        chk("lw_check_pulse", {31'h0, check_out}, 32'h0);

        // SW, three wait cycles then ack on the last allowed cycle.
        drive(1'b1, 32'h80, 32'h1234, {SW, 26'h9}, 1'b0, 32'h0);
        chk("sw_stall_idle", {31'h0, stall_out}, 32'h1);
        tick();
        drive(1'b1, 32'h1, 32'hFFFF, {LW, 26'h0}, 1'b0, 32'h0);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("sw_we_%0d", w),    {31'h0, dmem_we},   32'h1);
            chk($sformatf("sw_wd_%0d", w),    dmem_wdata,         32'h1234);
            chk($sformatf("sw_stall_%0d", w), {31'h0, stall_out}, 32'h1);
            chk($sformatf("sw_chk_%0d", w),   {31'h0, check_out}, 32'h0);
            tick();
            #0;
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D);
        chk("sw_wd_last",    dmem_wdata,         32'h1234);
        chk("sw_stall_ack",  {31'h0, stall_out}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("sw_check1",  {31'h0, check_out}, 32'h1);
        chk("sw_lmd",     lmd_out,            32'hDEAD_BEEF);
        chk("sw_alu",     alu_out,            32'h80);
        chk("sw_err",     {31'h0, err_out},   32'h0);
        chk("sw_req0",    {31'h0, dmem_req},  32'h0);
        tick();
        chk("sw_check_pulse", {31'h0, check_out}, 32'h0);

        // Timeout: ack never comes.
        drive(1'b1, 32'hC0, 32'h0, {LW, 26'h5}, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("to_req_%0d", w),   {31'h0, dmem_req},  32'h1);
            chk($sformatf("to_stall_%0d", w), {31'h0, stall_out}, 32'h1);
            tick();
        end
        chk("to_req_last",   {31'h0, dmem_req},  32'h1);
        chk("to_stall_last", {31'h0, stall_out}, 32'h0);
        tick();
        chk("to_req0",  {31'h0, dmem_req},  32'h0);
        chk("to_err",   {31'h0, err_out},   32'h1);
        chk("to_check", {31'h0, check_out}, 32'h0);
        chk("to_lmd",   lmd_out,            32'hDEAD_BEEF);
        drive(1'b1, 32'h77, 32'h0, 32'h0000_0022, 1'b0, 32'h0);
        chk("to_pt_stall", {31'h0, stall_out}, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("to_pt_check", {31'h0, check_out}, 32'h1);
        chk("to_pt_alu",   alu_out,            32'h77);
        tick();
        chk("to_err_sticky", {31'h0, err_out}, 32'h1);

        // Reset in the middle of an access.
        drive(1'b1, 32'h100, 32'h0, {LW, 26'h1}, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rs_req_before", {31'h0, dmem_req}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_req",   {31'h0, dmem_req},  32'h0);
        chk("rs_addr",  dmem_addr,          32'h0);
        chk("rs_err",   {31'h0, err_out},   32'h0);
        chk("rs_check", {31'h0, check_out}, 32'h0);
        chk("rs_alu",   alu_out,            32'h0);
        chk("rs_lmd",   lmd_out,            32'h0);
        chk("rs_ir",    ir_out,             32'h0);
        chk("rs_stall", {31'h0, stall_out}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1111_1111);
        for (int w = 0; w < 2; w++) begin
            tick();
            chk($sformatf("rs_nopulse_%0d", w), {31'h0, check_out}, 32'h0);
            chk($sformatf("rs_lmd_%0d", w),     lmd_out,            32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
